elevator_scheduler: RTL and testbench

- Sequences the car of the 4-floor elevator.
- Collects hall calls from the up/down button front-end (2-bit direction code, 2-bit floor) into pending-call registers.
- Runs a collective-scan policy: keep the current travel direction while calls exist ahead, reverse otherwise, idle when none remain.
- Drives the motor up/down commands and the door command, and reports the current floor to the display/top level.

---
 rtl/elevator_pkg.sv | 35 +++
 rtl/elevator_scheduler_call_register.sv | 77 +++++++
 rtl/elevator_scheduler.sv | 147 ++++++++++++++
 tb/tb_elevator_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor elevator scheduler.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  // Hall-call direction codes from the button front-end.
  localparam logic [1:0] DIR_UP   = 2'b11;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_NONE = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen
  } state_e;

  // Floors strictly above f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  // Floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

endpackage

// File: rtl/elevator_scheduler_call_register.sv
// Pending hall-call storage: filters and captures calls, clears a served floor, and
// reduces the pending bits to at/above/below flags relative to a query floor.
module elevator_scheduler_call_register
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [1:0]            req_dir,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic [FLOOR_W-1:0]    query_floor,
  output logic                  req_accept,
  output logic [NUM_FLOORS-1:0] up_pending,
  output logic [NUM_FLOORS-1:0] dn_pending,
  output logic                  up_at,
  output logic                  dn_at,
  output logic                  call_at,
  output logic                  call_above,
  output logic                  call_below
);

  logic [NUM_FLOORS-1:0] up_q, up_d, dn_q, dn_d, any_call;
  logic                  up_set, dn_set;

  // Decode the call code; up at the top floor and down at the bottom are meaningless.
  always_comb begin
    up_set = 1'b0;
    dn_set = 1'b0;
    case (req_dir)
      DIR_UP:   up_set = req_valid && (req_floor != FLOOR_W'(NUM_FLOORS - 1));
      DIR_DOWN: dn_set = req_valid && (req_floor != '0);
      DIR_NONE: ;
      default:  ;
    endcase
  end

  assign req_accept = up_set | dn_set;

  // Set first, then clear, so a clear of the same floor always wins.
  always_comb begin
    up_d = up_q;
    dn_d = dn_q;
    if (up_set) up_d[req_floor] = 1'b1;
    if (dn_set) dn_d[req_floor] = 1'b1;
    if (clr_en) begin
      up_d[clr_floor] = 1'b0;
      dn_d[clr_floor] = 1'b0;
    end
  end

  // Pending-call registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q <= '0;
      dn_q <= '0;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
    end
  end

  // Reduction flags relative to the query floor.
  always_comb begin
    any_call   = up_q | dn_q;
    up_at      = up_q[query_floor];
    dn_at      = dn_q[query_floor];
    call_at    = any_call[query_floor];
    call_above = |(any_call & above_mask(query_floor));
    call_below = |(any_call & below_mask(query_floor));
  end

  assign up_pending = up_q;
  assign dn_pending = dn_q;

endmodule

// File: rtl/elevator_scheduler.sv
// Collective-scan car sequencer: moves the car toward pending calls, stops to open the
// door, and reverses or idles when nothing remains ahead. All outputs are registered.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 100,
  parameter int unsigned DOOR_CYCLES   = 50,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [1:0]            req_dir,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] up_pending,
  output logic [NUM_FLOORS-1:0] dn_pending,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DoorLast   = CNT_W'(DOOR_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d, query_floor, clr_floor;
  logic                 dir_up_q, dir_up_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic                 motor_up_q, motor_down_q, door_open_q, busy_q;
  logic                 clr_en, req_accept, absorb, stop;
  logic                 up_at, dn_at, call_at, call_above, call_below;

  elevator_scheduler_call_register u_calls (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_dir     (req_dir),
    .req_floor   (req_floor),
    .clr_en      (clr_en),
    .clr_floor   (clr_floor),
    .query_floor (query_floor),
    .req_accept  (req_accept),
    .up_pending  (up_pending),
    .dn_pending  (dn_pending),
    .up_at       (up_at),
    .dn_at       (dn_at),
    .call_at     (call_at),
    .call_above  (call_above),
    .call_below  (call_below)
  );

  // While moving, evaluate the floor being approached; otherwise the floor we are at.
  always_comb begin
    query_floor = floor_q;
    if (state_q == StMoveUp)   query_floor = floor_q + 1'b1;
    if (state_q == StMoveDown) query_floor = floor_q - 1'b1;
  end

  // Stop on a same-direction call here or when nothing lies further on.
  assign stop   = (state_q == StMoveUp) ? (up_at || !call_above) : (dn_at || !call_below);
  assign absorb = (state_q == StDoorOpen) && req_accept && (req_floor == floor_q);

  // Next-state, floor, direction and timer decisions.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    timer_d   = timer_q + 1'b1;
    clr_en    = 1'b0;
    clr_floor = query_floor;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (call_at) begin
          state_d = StDoorOpen;
          clr_en  = 1'b1;
        end else if (call_above) begin
          state_d  = StMoveUp;
          dir_up_d = 1'b1;
        end else if (call_below) begin
          state_d  = StMoveDown;
          dir_up_d = 1'b0;
        end
      end
      StMoveUp, StMoveDown: begin
        if (timer_q == TravelLast) begin
          floor_d = query_floor;
          timer_d = '0;
          if (stop) begin
            state_d = StDoorOpen;
            clr_en  = 1'b1;
          end
        end
      end
      StDoorOpen: begin
        // Holding the clear on our floor keeps calls here from ever being registered.
        clr_en = 1'b1;
        if (absorb) begin
          timer_d = '0;
        end else if (timer_q == DoorLast) begin
          timer_d = '0;
          if (dir_up_q ? call_above : call_below) begin
            state_d = dir_up_q ? StMoveUp : StMoveDown;
          end else if (dir_up_q ? call_below : call_above) begin
            dir_up_d = !dir_up_q;
            state_d  = dir_up_q ? StMoveDown : StMoveUp;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; outputs follow the decided next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      floor_q      <= '0;
      dir_up_q     <= 1'b1;
      timer_q      <= '0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      timer_q      <= timer_d;
      motor_up_q   <= (state_d == StMoveUp);
      motor_down_q <= (state_d == StMoveDown);
      door_open_q  <= (state_d == StDoorOpen);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign current_floor = floor_q;
  assign motor_up      = motor_up_q;
  assign motor_down    = motor_down_q;
  assign door_open     = door_open_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: a floor-level reference model predicts every change of the
// output bundle with its cycle number; a monitor compares each change the DUT shows.
module tb_elevator_scheduler;

  localparam int TRAVEL_T = 4;
  localparam int DOOR_T   = 3;

  logic       clk, rst, req_valid;
  logic [1:0] req_dir, req_floor, current_floor;
  logic       motor_up, motor_down, door_open, busy;
  logic [3:0] up_pending, dn_pending;

  elevator_scheduler #(
    .TRAVEL_CYCLES (TRAVEL_T),
    .DOOR_CYCLES   (DOOR_T),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dir       (req_dir),
    .req_floor     (req_floor),
    .current_floor (current_floor),
    .motor_up      (motor_up),
    .motor_down    (motor_down),
    .door_open     (door_open),
    .up_pending    (up_pending),
    .dn_pending    (dn_pending),
    .busy          (busy)
  );

  typedef struct packed {
    logic [1:0] floor;
    logic       mu;
    logic       md;
    logic       door;
    logic [3:0] up;
    logic [3:0] dn;
    logic       busy;
  } obs_t;

  typedef struct {
    obs_t o;
    int   cyc;
  } ev_t;

  ev_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  bit  mon_en = 0;

  // Reference model: car position, motion (+1/-1/0), door, remaining cycles in activity.
  int m_floor, m_move, m_dir, m_left;
  bit m_door;
  bit m_up[4], m_dn[4];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_floor = 0; m_move = 0; m_dir = 1; m_left = 0; m_door = 0;
    for (int i = 0; i < 4; i++) begin m_up[i] = 0; m_dn[i] = 0; end
  endtask

  function automatic bit any_beyond(input int f, input int step);
    for (int g = f + step; g >= 0 && g < 4; g += step)
      if (m_up[g] || m_dn[g]) return 1;
    return 0;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [1:0] d, input logic [1:0] fl);
    int f, clr;
    bit is_call, absorbed;
    f = int'(fl);
    clr = -1;
    absorbed = 0;
    is_call = v && ((d == 2'b11 && f != 3) || (d == 2'b01 && f != 0));
    if (r) begin
      model_reset();
      return;
    end
    if (m_door) begin
      if (is_call && f == m_floor) begin
        absorbed = 1;
        m_left = DOOR_T;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_door = 0;
          if (any_beyond(m_floor, m_dir)) m_move = m_dir;
          else if (any_beyond(m_floor, -m_dir)) begin
            m_dir = -m_dir;
            m_move = m_dir;
          end
          if (m_move != 0) m_left = TRAVEL_T;
        end
      end
    end else if (m_move != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_floor += m_move;
        if ((m_move > 0 ? m_up[m_floor] : m_dn[m_floor]) || !any_beyond(m_floor, m_move)) begin
          clr = m_floor; m_move = 0; m_door = 1; m_left = DOOR_T;
        end else begin
          m_left = TRAVEL_T;
        end
      end
    end else begin
      if (m_up[m_floor] || m_dn[m_floor]) begin
        clr = m_floor; m_door = 1; m_left = DOOR_T;
      end else if (any_beyond(m_floor, 1)) begin
        m_dir = 1; m_move = 1; m_left = TRAVEL_T;
      end else if (any_beyond(m_floor, -1)) begin
        m_dir = -1; m_move = -1; m_left = TRAVEL_T;
      end
    end
    if (is_call && !absorbed) begin
      if (d == 2'b11) m_up[f] = 1;
      else m_dn[f] = 1;
    end
    if (clr >= 0) begin
      m_up[clr] = 0;
      m_dn[clr] = 0;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    o.floor = 2'(m_floor);
    o.mu    = (m_move > 0);
    o.md    = (m_move < 0);
    o.door  = m_door;
    for (int i = 0; i < 4; i++) begin o.up[i] = m_up[i]; o.dn[i] = m_dn[i]; end
    o.busy  = (m_move != 0) || m_door;
    return o;
  endfunction

  // Model advances at each active edge with the inputs the DUT samples there.
  initial begin
    obs_t cur, prev;
    ev_t  e;
    model_reset();
    prev = model_out();
    forever begin
      @(posedge clk);
      cyc++;
      model_edge(rst, req_valid, req_dir, req_floor);
      cur = model_out();
      if (cur != prev) begin
        e.o = cur;
        e.cyc = cyc;
        sb_q.push_back(e);
        prev = cur;
      end
    end
  end

  // Monitor: on every visible change of the DUT outputs, pop and compare.
  initial begin
    obs_t dprev, dcur;
    ev_t  e;
    dprev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        dcur = obs_t'({current_floor, motor_up, motor_down, door_open,
                       up_pending, dn_pending, busy});
        checks++;
        if (motor_up === 1'b1 && motor_down === 1'b1) begin
          errors++;
          $display("FAIL motor_exclusive cyc=%0d got up=1 down=1 need not both", cyc);
        end
        if (dcur !== dprev) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL out_event cyc=%0d got=%h expected no change", cyc, dcur);
          end else begin
            e = sb_q.pop_front();
            if (e.o !== dcur || e.cyc != cyc) begin
              errors++;
              $display("FAIL out_event got=%h at cyc %0d, need=%h at cyc %0d",
                       dcur, cyc, e.o, e.cyc);
            end
          end
          dprev = dcur;
        end
      end
    end
  end

  task automatic call(input logic [1:0] d, input logic [1:0] f);
    req_valid = 1; req_dir = d; req_floor = f;
    @(negedge clk);
    req_valid = 0; req_dir = 2'b00; req_floor = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%h need=%h", name, got, need);
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_dir = 2'b00; req_floor = 2'b00;
    repeat (3) @(negedge clk);
    rst = 0;
    mon_en = 1;
    idle(20);
    check("reset_idle", 32'({current_floor, motor_up, motor_down, door_open,
                             up_pending, dn_pending, busy}), 32'd0);

    call(2'b11, 2'd0); idle(10);                      // door at floor 0, no motion
    call(2'b01, 2'd2); idle(20);                      // travel 0 -> 2
    call(2'b11, 2'd0); idle(20);                      // back to 0
    call(2'b11, 2'd1); call(2'b01, 2'd1); idle(20);   // both calls at 1 cleared on stop
    call(2'b01, 2'd3); idle(20);                      // up to 3
    call(2'b11, 2'd1); call(2'b01, 2'd2); idle(30);   // stop at 2 then 1

    call(2'b10, 2'd2); call(2'b11, 2'd3); call(2'b01, 2'd0); idle(3);
    check("illegal_ignored", 32'({up_pending, dn_pending}), 32'd0);

    call(2'b01, 2'd3); idle(2);                       // car at 1 heading up
    check("moving_before_rst", 32'({current_floor, motor_up}), 32'({2'd1, 1'b1}));
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_move", 32'({current_floor, motor_up, motor_down, door_open, busy}), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      req_valid = ($urandom_range(0, 3) == 0);
      req_dir   = 2'($urandom);
      req_floor = 2'($urandom);
      @(negedge clk);
    end
    rst = 0; req_valid = 0; req_dir = 2'b00; req_floor = 2'b00;

    // Drain: bounded wait for the model to settle, then expect an empty scoreboard.
    for (int i = 0; i < 400 && (m_move != 0 || m_door || any_beyond(-1, 1)); i++)
      @(negedge clk);
    idle(5);
    checks++;
    if (sb_q.size() != 0 || m_move != 0 || m_door) begin
      errors++;
      $display("FAIL drain got %0d pending events, need 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
